// File: rtl/branch_predict_resolve_if.sv
// EX/IF-facing signal bundle for the branch resolver; the pipeline drives the
// master side and the resolver sits on the slave side.
interface branch_predict_resolve_if #(
  parameter int PERF_W = 32
);
  logic [31:0]       IF_PC;
  logic              IF_PRED_TAKEN;
  logic              EX_VALID;
  logic [31:0]       EX_PC;
  logic [1:0]        BRANCH_SEL;
  logic              ZERO;
  logic              EX_PRED_TAKEN;
  logic              STALL;
  logic              PC_SEL;
  logic              MISPREDICT;
  logic [PERF_W-1:0] BR_COUNT;
  logic [PERF_W-1:0] MISS_COUNT;

  modport master (
    output IF_PC, EX_VALID, EX_PC, BRANCH_SEL, ZERO, EX_PRED_TAKEN, STALL,
    input  IF_PRED_TAKEN, PC_SEL, MISPREDICT, BR_COUNT, MISS_COUNT
  );

  modport slave (
    input  IF_PC, EX_VALID, EX_PC, BRANCH_SEL, ZERO, EX_PRED_TAKEN, STALL,
    output IF_PRED_TAKEN, PC_SEL, MISPREDICT, BR_COUNT, MISS_COUNT
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// Bimodal BHT predictor with EX-stage direction resolution, misprediction
// flagging and saturating branch/miss performance counters.
module branch_predict_resolve #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CNT_INIT   = 2'b01,
  parameter int         PERF_W     = 32
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  branch_predict_resolve_if.slave   bus
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_BEQ  = 2'b01;
  localparam logic [1:0] SEL_BNE  = 2'b10;
  localparam logic [1:0] SEL_JMP  = 2'b11;

  logic [1:0]            bht [ENTRIES];
  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic                  pc_sel, mispredict;
  logic                  is_cond, commit, bht_upd, miss_upd;
  logic [1:0]            cur_cnt, nxt_cnt;
  logic [PERF_W-1:0]     br_count, miss_count;

  assign if_idx = bus.IF_PC[INDEX_BITS+1:2];
  assign ex_idx = bus.EX_PC[INDEX_BITS+1:2];

  always_comb begin
    pc_sel = 1'b0;
    if (bus.EX_VALID) begin
      case (bus.BRANCH_SEL)
        SEL_NONE: pc_sel = 1'b0;
        SEL_BEQ:  pc_sel = bus.ZERO;
        SEL_BNE:  pc_sel = ~bus.ZERO;
        SEL_JMP:  pc_sel = 1'b1;
        default:  pc_sel = 1'b0;
      endcase
    end
  end

  assign mispredict = bus.EX_VALID & (pc_sel != bus.EX_PRED_TAKEN);

  // Only conditional branches train the table; jumps and non-branches can
  // still count a miss when fetch guessed wrong.
  assign is_cond  = (bus.BRANCH_SEL == SEL_BEQ) || (bus.BRANCH_SEL == SEL_BNE);
  assign commit   = bus.EX_VALID & ~bus.STALL;
  assign bht_upd  = commit & is_cond;
  assign miss_upd = commit & mispredict;

  assign cur_cnt = bht[ex_idx];

  always_comb begin
    nxt_cnt = cur_cnt;
    if (pc_sel) begin
      if (cur_cnt != 2'b11) nxt_cnt = cur_cnt + 2'b01;
    end else begin
      if (cur_cnt != 2'b00) nxt_cnt = cur_cnt - 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= CNT_INIT;
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      if (bht_upd) begin
        bht[ex_idx] <= nxt_cnt;
        if (br_count != '1) br_count <= br_count + 1'b1;
      end
      if (miss_upd && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end

  // Prediction reads the registered table: no bypass from a same-cycle update.
  assign bus.IF_PRED_TAKEN = bht[if_idx][1];
  assign bus.PC_SEL        = pc_sel;
  assign bus.MISPREDICT    = mispredict;
  assign bus.BR_COUNT      = br_count;
  assign bus.MISS_COUNT    = miss_count;
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Randomized + directed bench; a 32-bit and a 4-bit perf-counter instance
// share stimulus and are checked against a behavioural model.
module tb_branch_predict_resolve;
  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  branch_predict_resolve_if #(.PERF_W(32)) bus ();
  branch_predict_resolve_if #(.PERF_W(4))  bus4 ();

  assign bus4.IF_PC         = bus.IF_PC;
  assign bus4.EX_VALID      = bus.EX_VALID;
  assign bus4.EX_PC         = bus.EX_PC;
  assign bus4.BRANCH_SEL    = bus.BRANCH_SEL;
  assign bus4.ZERO          = bus.ZERO;
  assign bus4.EX_PRED_TAKEN = bus.EX_PRED_TAKEN;
  assign bus4.STALL         = bus.STALL;

  branch_predict_resolve #(.INDEX_BITS(6), .CNT_INIT(2'b01), .PERF_W(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus));
  branch_predict_resolve #(.INDEX_BITS(6), .CNT_INIT(2'b01), .PERF_W(4)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  int          bht_m [64];
  longint unsigned br_m, miss_m, br4_m, miss4_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit actual_taken(input bit v, input logic [1:0] sel, input bit z);
    if (!v) return 1'b0;
    case (sel)
      2'd1:    return z;
      2'd2:    return !z;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    br_m = 0; miss_m = 0; br4_m = 0; miss4_m = 0;
  endtask

  function automatic longint unsigned sat_inc(input longint unsigned c, input longint unsigned mx);
    return (c >= mx) ? mx : c + 1;
  endfunction

  task automatic check_counts(input string tag);
    chk({tag, ".br"},    64'(bus.BR_COUNT),    br_m);
    chk({tag, ".miss"},  64'(bus.MISS_COUNT),  miss_m);
    chk({tag, ".br4"},   64'(bus4.BR_COUNT),   br4_m);
    chk({tag, ".miss4"}, 64'(bus4.MISS_COUNT), miss4_m);
  endtask

  // One cycle: drive at negedge, check combinational outputs and counters
  // shortly after, then advance the model across the next rising edge.
  task automatic step(input logic [31:0] ifpc, input logic [31:0] expc, input bit v,
                      input logic [1:0] sel, input bit z, input bit p, input bit st);
    bit t, m;
    int e;
    @(negedge CLK);
    bus.IF_PC = ifpc; bus.EX_PC = expc; bus.EX_VALID = v; bus.BRANCH_SEL = sel;
    bus.ZERO = z; bus.EX_PRED_TAKEN = p; bus.STALL = st;
    #1;
    t = actual_taken(v, sel, z);
    m = v && (t != p);
    chk("pred",    64'(bus.IF_PRED_TAKEN),  64'(bht_m[idx_of(ifpc)] >= 2));
    chk("pred4",   64'(bus4.IF_PRED_TAKEN), 64'(bht_m[idx_of(ifpc)] >= 2));
    chk("pc_sel",  64'(bus.PC_SEL),         64'(t));
    chk("mispred", 64'(bus.MISPREDICT),     64'(m));
    check_counts("cnt");
    if (v && !st) begin
      if (sel == 2'd1 || sel == 2'd2) begin
        e = idx_of(expc);
        bht_m[e] = t ? ((bht_m[e] + 1 > 3) ? 3 : bht_m[e] + 1)
                     : ((bht_m[e] - 1 < 0) ? 0 : bht_m[e] - 1);
        br_m  = sat_inc(br_m, 64'hFFFF_FFFF);
        br4_m = sat_inc(br4_m, 15);
      end
      if (m) begin
        miss_m  = sat_inc(miss_m, 64'hFFFF_FFFF);
        miss4_m = sat_inc(miss4_m, 15);
      end
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle, well away from either edge.
  task automatic mid_reset();
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    bus.IF_PC = $urandom;
    #1;
    model_reset();
    chk("rst.pred", 64'(bus.IF_PRED_TAKEN), 64'(0));
    check_counts("rst");
    #1 RESET_N = 1'b1;
  endtask

  function automatic logic [31:0] rnd_pc();
    return ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    RESET_N = 1'b0;
    bus.IF_PC = 32'h40; bus.EX_PC = '0; bus.EX_VALID = 1'b0; bus.BRANCH_SEL = 2'b00;
    bus.ZERO = 1'b0; bus.EX_PRED_TAKEN = 1'b0; bus.STALL = 1'b0;
    model_reset();
    #2;
    chk("init.pred", 64'(bus.IF_PRED_TAKEN), 64'(0));
    check_counts("init");
    @(negedge CLK);
    RESET_N = 1'b1;

    // Training at index 16: 01->10->11->11, then back down to 01.
    repeat (3) step(32'h40, 32'h40, 1, 2'b01, 1, 0, 0);
    repeat (2) step(32'h40, 32'h40, 1, 2'b01, 0, 1, 0);
    step(32'h40, 32'h0, 0, 2'b00, 0, 0, 0);
    chk("train.final", 64'(bus.IF_PRED_TAKEN), 64'(0));

    // Full resolution truth table, valid and bubble.
    for (int v = 0; v < 2; v++)
      for (int s = 0; s < 4; s++)
        for (int z = 0; z < 2; z++)
          for (int p = 0; p < 2; p++)
            step(32'h80, 32'h80, v[0], s[1:0], z[0], p[0], 0);

    // Stall freeze with a valid mispredicted BNE.
    repeat (4) step(32'h84, 32'h84, 1, 2'b10, 0, 0, 1);

    // Same-index collision on a fresh table.
    mid_reset();
    step(32'h100, 32'h100, 1, 2'b01, 1, 1, 0);
    step(32'h100, 32'h0,   0, 2'b00, 0, 0, 0);
    chk("coll.after", 64'(bus.IF_PRED_TAKEN), 64'(1));
    step(32'h104, 32'h0,   0, 2'b00, 0, 0, 0);
    chk("coll.neigh", 64'(bus.IF_PRED_TAKEN), 64'(0));

    // Randomized traffic over a small aliasing index set.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) mid_reset();
      step(rnd_pc(), rnd_pc(), ($urandom_range(0, 3) != 0), 2'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
    end

    // Counter saturation: 20 mispredicted conditional branches.
    mid_reset();
    repeat (20) step(rnd_pc(), rnd_pc(), 1, 2'b01, 1, 0, 0);
    @(negedge CLK); #1;
    chk("sat.br4",   64'(bus4.BR_COUNT),   64'(15));
    chk("sat.miss4", 64'(bus4.MISS_COUNT), 64'(15));
    chk("sat.br32",  64'(bus.BR_COUNT),    64'(20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
